h_pc_stack: RTL and testbench



---
 rtl/h_pc_stack.sv | 98 +++++++++
 tb/tb_h_pc_stack.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/h_pc_stack.sv
// rtl/h_pc_stack.sv - program counter with hardware call/return stack
module h_pc_stack #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 8,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inc,
  input  logic                       load,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           addr,
  output logic [WIDTH-1:0]           pc,
  output logic [WIDTH-1:0]           tos,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       err
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

  logic [WIDTH-1:0] stk [DEPTH];
  logic [DW-1:0]    cnt;
  logic [DW-1:0]    cnt_m1;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] pc_plus1;

  logic             do_push;
  logic             set_err;
  logic [WIDTH-1:0] pc_nxt;
  logic [DW-1:0]    cnt_nxt;

  assign cnt_m1   = cnt - DW'(1);
  assign wr_idx   = cnt[AW-1:0];
  assign top_idx  = cnt_m1[AW-1:0];
  assign pc_plus1 = pc + WIDTH'(1);

  assign depth = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign tos   = empty ? '0 : stk[top_idx];

  // Priority decode: call > ret > load > inc > hold; one action per cycle.
  always_comb begin
    pc_nxt  = pc;
    cnt_nxt = cnt;
    do_push = 1'b0;
    set_err = 1'b0;
    if (call) begin
      pc_nxt = addr;
      if (full) begin
        set_err = 1'b1;
      end else begin
        do_push = 1'b1;
        cnt_nxt = cnt + DW'(1);
      end
    end else if (ret) begin
      if (empty) begin
        set_err = 1'b1;
      end else begin
        pc_nxt  = stk[top_idx];
        cnt_nxt = cnt_m1;
      end
    end else if (load) begin
      pc_nxt = addr;
    end else if (inc) begin
      pc_nxt = pc_plus1;
    end
  end

  // Control state: pc, stack depth and the sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc  <= RESET_ADDR;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      pc  <= pc_nxt;
      cnt <= cnt_nxt;
      if (set_err) begin
        err <= 1'b1;
      end
    end
  end

  // Stack storage is never cleared; depth alone marks entries valid.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      stk[wr_idx] <= pc_plus1;
    end
  end

endmodule

// File: tb/tb_h_pc_stack.sv
// tb/tb_h_pc_stack.sv - directed self-checking bench for h_pc_stack
module tb_h_pc_stack;

  logic        clk;
  logic        rst_n;
  logic        inc;
  logic        load;
  logic        call;
  logic        ret;
  logic [15:0] addr;
  logic [15:0] pc;
  logic [15:0] tos;
  logic [3:0]  depth;
  logic        empty;
  logic        full;
  logic        err;

  int checks   = 0;
  int failures = 0;

  h_pc_stack #(.WIDTH(16), .DEPTH(8), .RESET_ADDR(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .load  (load),
    .call  (call),
    .ret   (ret),
    .addr  (addr),
    .pc    (pc),
    .tos   (tos),
    .depth (depth),
    .empty (empty),
    .full  (full),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic i, input logic l, input logic c,
                      input logic t, input logic [15:0] a);
    rst_n = r;
    inc   = i;
    load  = l;
    call  = c;
    ret   = t;
    addr  = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; inc = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0; addr = '0;

    // Reset held two cycles with commands active
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234);
      check("rst_pc", pc, 32'h0);
      check("rst_depth", depth, 32'h0);
      check("rst_empty", empty, 32'h1);
      check("rst_full", full, 32'h0);
      check("rst_err", err, 32'h0);
      check("rst_tos", tos, 32'h0);
    end
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      check("inc_pc", pc, 32'(k));
    end

    // Wrap and jump
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE);
    check("load_fffe", pc, 32'hFFFE);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check("inc_ffff", pc, 32'hFFFF);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check("wrap_0", pc, 32'h0);
    check("wrap_err", err, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0040);
    check("load_over_inc", pc, 32'h0040);

    // Nested call/return
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0100);
    check("call1_pc", pc, 32'h0100);
    check("call1_tos", tos, 32'h0011);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0200);
    check("call2_pc", pc, 32'h0200);
    check("call2_depth", depth, 32'h2);
    check("call2_tos", tos, 32'h0101);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    check("ret1_pc", pc, 32'h0101);
    check("ret1_tos", tos, 32'h0011);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    check("ret2_pc", pc, 32'h0011);
    check("ret2_empty", empty, 32'h1);
    check("ret2_err", err, 32'h0);

    // Hold leaves everything unchanged
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7777);
    check("hold_pc", pc, 32'h0011);

    // Overflow: calls from pc=0..7 each to pc+1, pushing 1..8
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'(k + 1));
      check("fill_depth", depth, 32'(k + 1));
      check("fill_tos", tos, 32'(k + 1));
    end
    check("fill_full", full, 32'h1);
    check("fill_err", err, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0300);
    check("ovf_pc", pc, 32'h0300);
    check("ovf_depth", depth, 32'h8);
    check("ovf_err", err, 32'h1);
    check("ovf_tos", tos, 32'h8);
    for (int k = 8; k >= 1; k--) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      check("pop_pc", pc, 32'(k));
      check("pop_depth", depth, 32'(k - 1));
    end
    check("pop_empty", empty, 32'h1);
    check("pop_tos", tos, 32'h0);

    // Reset mid-sequence discards stack and clears err
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0123);
    check("pre_rst_depth", depth, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0456);
    check("midrst_pc", pc, 32'h0);
    check("midrst_depth", depth, 32'h0);
    check("midrst_tos", tos, 32'h0);
    check("midrst_err", err, 32'h0);

    // Underflow
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0050);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    check("unf_pc", pc, 32'h0050);
    check("unf_depth", depth, 32'h0);
    check("unf_err", err, 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check("unf_inc_pc", pc, 32'h0051);
    check("unf_inc_err", err, 32'h1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0005);
    check("unf_load_err", err, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    check("unf_rst_err", err, 32'h0);

    // Simultaneous commands
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0005);
    check("sim_pre_pc", pc, 32'h0005);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0A00);
    check("sim_call_pc", pc, 32'h0A00);
    check("sim_call_depth", depth, 32'h1);
    check("sim_call_tos", tos, 32'h0006);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0B00);
    check("sim_ret_pc", pc, 32'h0006);
    check("sim_ret_depth", depth, 32'h0);

    // ret followed by call reuses the freed slot
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0C00);
    check("reuse_tos", tos, 32'h0007);
    check("reuse_depth", depth, 32'h1);
    check("final_err", err, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
